// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding, branch-flush and halt controller for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 4,
    parameter bit FWD_EN   = 1'b1,
    parameter int BR_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_halt,
    input  logic              id_br_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_nop,
    output logic [1:0]        ex_fwd1_sel,
    output logic [1:0]        ex_fwd2_sel,
    output logic              hlt,
    output logic [15:0]       stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] FLUSH_LOAD = 2'(BR_FLUSH - 1);

    // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB. WB only needs valid/halt
    // because the register file bypasses writes to same-cycle reads.
    logic [2:0]             e_valid_q, e_valid_d;
    logic [2:0]             e_halt_q,  e_halt_d;
    logic [1:0]             e_rw_q,    e_rw_d;
    logic [1:0][REG_AW-1:0] e_dst_q,   e_dst_d;
    logic                   e0_load_q, e0_load_d;

    logic        halted_q, halted_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [1:0]  fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic        hlt_q, hlt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic m1_e0, m2_e0, m1_e1, m2_e1;
    logic hazard, stall, accept, halt_now, br_now;

    function automatic logic src_match(input logic v, input logic rw, input logic used,
                                       input logic [REG_AW-1:0] dst,
                                       input logic [REG_AW-1:0] src);
        return v & rw & used & (dst == src) & (src != '0);
    endfunction

    always_comb begin
        m1_e0 = src_match(e_valid_q[0], e_rw_q[0], id_src1_used, e_dst_q[0], id_src1);
        m2_e0 = src_match(e_valid_q[0], e_rw_q[0], id_src2_used, e_dst_q[0], id_src2);
        m1_e1 = src_match(e_valid_q[1], e_rw_q[1], id_src1_used, e_dst_q[1], id_src1);
        m2_e1 = src_match(e_valid_q[1], e_rw_q[1], id_src2_used, e_dst_q[1], id_src2);

        if (FWD_EN) begin
            hazard = (m1_e0 | m2_e0) & e0_load_q;
        end else begin
            hazard = m1_e0 | m2_e0 | m1_e1 | m2_e1;
        end

        stall    = id_valid & ~halted_q & hazard;
        accept   = id_valid & ~halted_q & ~stall;
        halt_now = accept & id_halt;
        br_now   = accept & id_br_taken;

        // The HLT itself still enters EX; everything fetched behind it is dropped.
        pc_we      = ~(halted_q | halt_now | stall);
        ifid_we    = ~(halted_q | halt_now | stall);
        idex_nop   = halted_q | stall;
        ifid_flush = halted_q | halt_now | (~stall & (br_now | (flush_cnt_q != 2'd0)));
    end

    always_comb begin
        e_valid_d = {e_valid_q[1:0], accept};
        e_halt_d  = {e_halt_q[1:0],  accept & id_halt};
        e_rw_d    = {e_rw_q[0],      accept & id_regwrite};
        e_dst_d   = {e_dst_q[0],     id_dst};
        e0_load_d = accept & id_memread;

        halted_d = halted_q | halt_now;

        if (br_now) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != 2'd0) begin
            flush_cnt_d = flush_cnt_q - 2'd1;
        end else begin
            flush_cnt_d = 2'd0;
        end

        fwd1_d = SEL_RF;
        fwd2_d = SEL_RF;
        if (FWD_EN && accept) begin
            fwd1_d = m1_e0 ? SEL_MEM : (m1_e1 ? SEL_WB : SEL_RF);
            fwd2_d = m2_e0 ? SEL_MEM : (m2_e1 ? SEL_WB : SEL_RF);
        end

        hlt_d = hlt_q | (e_valid_q[2] & e_halt_q[2]);

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q   <= '0;
            e_halt_q    <= '0;
            e_rw_q      <= '0;
            e_dst_q     <= '0;
            e0_load_q   <= 1'b0;
            halted_q    <= 1'b0;
            flush_cnt_q <= 2'd0;
            fwd1_q      <= SEL_RF;
            fwd2_q      <= SEL_RF;
            hlt_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            e_valid_q   <= e_valid_d;
            e_halt_q    <= e_halt_d;
            e_rw_q      <= e_rw_d;
            e_dst_q     <= e_dst_d;
            e0_load_q   <= e0_load_d;
            halted_q    <= halted_d;
            flush_cnt_q <= flush_cnt_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            hlt_q       <= hlt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_fwd1_sel = fwd1_q;
    assign ex_fwd2_sel = fwd2_q;
    assign hlt         = hlt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_src1_used, id_src2_used, id_regwrite, id_memread, id_halt, id_br_taken;
    logic [3:0] id_src1, id_src2, id_dst;

    logic        f_pc_we, f_ifid_we, f_ifid_flush, f_idex_nop, f_hlt;
    logic [1:0]  f_fwd1, f_fwd2;
    logic [15:0] f_stall_cnt;
    logic        n_pc_we, n_ifid_we, n_ifid_flush, n_idex_nop, n_hlt;
    logic [1:0]  n_fwd1, n_fwd2;
    logic [15:0] n_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(1'b1), .BR_FLUSH(2)) u_f (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_halt(id_halt), .id_br_taken(id_br_taken),
        .pc_we(f_pc_we), .ifid_we(f_ifid_we), .ifid_flush(f_ifid_flush),
        .idex_nop(f_idex_nop), .ex_fwd1_sel(f_fwd1), .ex_fwd2_sel(f_fwd2),
        .hlt(f_hlt), .stall_cnt(f_stall_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(1'b0), .BR_FLUSH(1)) u_n (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_halt(id_halt), .id_br_taken(id_br_taken),
        .pc_we(n_pc_we), .ifid_we(n_ifid_we), .ifid_flush(n_ifid_flush),
        .idex_nop(n_idex_nop), .ex_fwd1_sel(n_fwd1), .ex_fwd2_sel(n_fwd2),
        .hlt(n_hlt), .stall_cnt(n_stall_cnt)
    );

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic [3:0] d,
                          input logic rw, input logic ld, input logic h, input logic br);
        id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
        id_dst = d; id_regwrite = rw; id_memread = ld; id_halt = h; id_br_taken = br;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        n_checks++; if (f_pc_we !== 1'b1)      begin n_fail++; $display("FAIL reset_pc_we got %b exp 1", f_pc_we); end
        n_checks++; if (f_ifid_we !== 1'b1)    begin n_fail++; $display("FAIL reset_ifid_we got %b exp 1", f_ifid_we); end
        n_checks++; if (f_ifid_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", f_ifid_flush); end
        n_checks++; if (f_idex_nop !== 1'b0)   begin n_fail++; $display("FAIL reset_idex_nop got %b exp 0", f_idex_nop); end
        n_checks++; if ({f_fwd1, f_fwd2} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got %b%b exp 0000", f_fwd1, f_fwd2); end
        n_checks++; if (f_hlt !== 1'b0)        begin n_fail++; $display("FAIL reset_hlt got %b exp 0", f_hlt); end
        n_checks++; if (f_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", f_stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fwd_alu();
        do_reset();
        cyc(); set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0, 0);
        cyc(); set_id(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0, 0, 0);
        #1;
        n_checks++; if (f_pc_we !== 1'b1) begin n_fail++; $display("FAIL alu_no_stall pc_we got %b exp 1", f_pc_we); end
        cyc(); idle(); #1;
        n_checks++; if (f_fwd1 !== 2'b01) begin n_fail++; $display("FAIL alu_fwd1 got %b exp 01", f_fwd1); end
        n_checks++; if (f_fwd2 !== 2'b00) begin n_fail++; $display("FAIL alu_fwd2 got %b exp 00", f_fwd2); end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(); set_id(1, 4'd2, 1, 4'd0, 0, 4'd1, 1, 1, 0, 0);
        cyc(); set_id(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0, 0);
        #1;
        n_checks++; if ({f_pc_we, f_ifid_we, f_idex_nop} !== 3'b001) begin n_fail++; $display("FAIL lu_stall got %b exp 001", {f_pc_we, f_ifid_we, f_idex_nop}); end
        cyc(); #1;
        n_checks++; if ({f_pc_we, f_ifid_we, f_idex_nop} !== 3'b110) begin n_fail++; $display("FAIL lu_release got %b exp 110", {f_pc_we, f_ifid_we, f_idex_nop}); end
        n_checks++; if ({f_fwd1, f_fwd2} !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble_fwd got %b exp 0000", {f_fwd1, f_fwd2}); end
        cyc(); idle(); #1;
        n_checks++; if ({f_fwd1, f_fwd2} !== 4'b1010) begin n_fail++; $display("FAIL lu_fwd got %b exp 1010", {f_fwd1, f_fwd2}); end
        n_checks++; if (f_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 1", f_stall_cnt); end
    endtask

    task automatic test_no_fwd();
        do_reset();
        cyc(); set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0, 0);
        cyc(); set_id(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0, 0, 0);
        #1;
        n_checks++; if (n_pc_we !== 1'b0) begin n_fail++; $display("FAIL nf_adj_stall1 got %b exp 0", n_pc_we); end
        cyc(); #1;
        n_checks++; if (n_pc_we !== 1'b0) begin n_fail++; $display("FAIL nf_adj_stall2 got %b exp 0", n_pc_we); end
        cyc(); #1;
        n_checks++; if (n_pc_we !== 1'b1) begin n_fail++; $display("FAIL nf_adj_go got %b exp 1", n_pc_we); end
        cyc(); idle(); #1;
        n_checks++; if ({n_fwd1, n_fwd2} !== 4'b0000) begin n_fail++; $display("FAIL nf_fwd got %b exp 0000", {n_fwd1, n_fwd2}); end
        n_checks++; if (n_stall_cnt !== 16'd2) begin n_fail++; $display("FAIL nf_adj_cnt got %0d exp 2", n_stall_cnt); end

        do_reset();
        cyc(); set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 0, 0);
        cyc(); set_id(1, 4'd2, 1, 4'd3, 1, 4'd6, 1, 0, 0, 0);
        cyc(); set_id(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0, 0, 0);
        #1;
        n_checks++; if (n_pc_we !== 1'b0) begin n_fail++; $display("FAIL nf_gap_stall got %b exp 0", n_pc_we); end
        cyc(); #1;
        n_checks++; if (n_pc_we !== 1'b1) begin n_fail++; $display("FAIL nf_gap_go got %b exp 1", n_pc_we); end
        cyc(); idle(); #1;
        n_checks++; if (n_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL nf_gap_cnt got %0d exp 1", n_stall_cnt); end
    endtask

    task automatic test_r0();
        do_reset();
        cyc(); set_id(1, 4'd2, 1, 4'd0, 0, 4'd0, 1, 1, 0, 0);
        cyc(); set_id(1, 4'd0, 1, 4'd0, 1, 4'd3, 1, 0, 0, 0);
        #1;
        n_checks++; if ({f_pc_we, n_pc_we} !== 2'b11) begin n_fail++; $display("FAIL r0_no_stall got %b exp 11", {f_pc_we, n_pc_we}); end
        cyc(); idle(); #1;
        n_checks++; if ({f_fwd1, f_fwd2} !== 4'b0000) begin n_fail++; $display("FAIL r0_fwd got %b exp 0000", {f_fwd1, f_fwd2}); end
    endtask

    task automatic test_branch();
        do_reset();
        cyc(); set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1);
        #1;
        n_checks++; if ({f_ifid_flush, n_ifid_flush} !== 2'b11) begin n_fail++; $display("FAIL br_t got %b exp 11", {f_ifid_flush, n_ifid_flush}); end
        cyc(); idle(); #1;
        n_checks++; if ({f_ifid_flush, n_ifid_flush} !== 2'b10) begin n_fail++; $display("FAIL br_t1 got %b exp 10", {f_ifid_flush, n_ifid_flush}); end
        cyc(); #1;
        n_checks++; if (f_ifid_flush !== 1'b0) begin n_fail++; $display("FAIL br_t2 got %b exp 0", f_ifid_flush); end
    endtask

    task automatic test_halt();
        do_reset();
        cyc(); set_id(1, 4'd2, 1, 4'd0, 0, 4'd1, 1, 1, 0, 0);
        cyc(); set_id(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0, 0);
        cyc();
        cyc(); set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
        #1;
        n_checks++; if ({f_pc_we, f_ifid_we, f_ifid_flush} !== 3'b001) begin n_fail++; $display("FAIL halt_t got %b exp 001", {f_pc_we, f_ifid_we, f_ifid_flush}); end
        cyc(); set_id(1, 4'd2, 1, 4'd3, 1, 4'd7, 1, 0, 0, 0); #1;
        n_checks++; if ({f_pc_we, f_idex_nop} !== 2'b01) begin n_fail++; $display("FAIL halt_t1 got %b exp 01", {f_pc_we, f_idex_nop}); end
        cyc();
        cyc(); #1;
        n_checks++; if (f_hlt !== 1'b0) begin n_fail++; $display("FAIL halt_t3 hlt got %b exp 0", f_hlt); end
        cyc(); #1;
        n_checks++; if (f_hlt !== 1'b1) begin n_fail++; $display("FAIL halt_t4 hlt got %b exp 1", f_hlt); end
        n_checks++; if (f_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL halt_cnt got %0d exp 1", f_stall_cnt); end
        #2; rst_n = 1'b0; #1;
        n_checks++; if ({f_hlt, f_pc_we} !== 2'b01) begin n_fail++; $display("FAIL halt_rst got %b exp 01", {f_hlt, f_pc_we}); end
        @(negedge clk); rst_n = 1'b1;

        cyc(); set_id(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0);
        cyc(); idle();
        #2; rst_n = 1'b0; #1;
        n_checks++; if ({f_pc_we, f_ifid_flush} !== 2'b10) begin n_fail++; $display("FAIL drain_rst got %b exp 10", {f_pc_we, f_ifid_flush}); end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) cyc();
        n_checks++; if (f_hlt !== 1'b0) begin n_fail++; $display("FAIL drain_hlt got %b exp 0", f_hlt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_no_fwd();
        test_r0();
        test_branch();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
